// File: rtl/ll_rx_auto_sync.sv
`default_nettype none
// ============================================================================
//  Module   : ll_rx_auto_sync
//  Purpose  : Receive-side strobe auto-sync for the logic-link. Watches the
//             strobe/marker userbits of each received word, decides when the
//             strobe is aligned, flags alignment errors and forwards the
//             userbits to the RX FIFO data path (sync strobes removed).
//  Clocking : single domain clk_wr, asynchronous active-low reset rst_wr_n.
//  Ports    :
//     clk_wr               in   clock
//     rst_wr_n             in   async active-low reset
//     rx_online            in   link online; low forces IDLE
//     stb_period[7:0]      in   words between strobes (persistent mode)
//     rx_stb_userbit       in   received strobe bit
//     rx_mrk_userbit[M-1:0]in   received marker bits
//     rx_strobe_aligned    out  registered lock status
//     rx_align_err         out  registered one-cycle error pulse
//     rx_auto_stb_userbit  out  strobe to data path (zero latency)
//     rx_auto_mrk_userbit  out  marker to data path (pass-through)
//     rx_relock_cnt[7:0]   out  LOCKED->SEARCH count (only with macro)
//  Option   : `define LL_RX_AUTOSYNC_RELOCK_CNT_EN adds rx_relock_cnt.
//  Revision : 1.0  initial release
// ============================================================================
module ll_rx_auto_sync #(
   parameter int   MARKER_WIDTH      = 1,
   parameter logic PERSISTENT_STROBE = 1'b1,
   parameter logic NO_MARKER         = 1'b0,
   parameter int   LOCK_COUNT        = 3
) (
   input  logic                    clk_wr,
   input  logic                    rst_wr_n,
   input  logic                    rx_online,
   input  logic [7:0]              stb_period,
   input  logic                    rx_stb_userbit,
   input  logic [MARKER_WIDTH-1:0] rx_mrk_userbit,
   output logic                    rx_strobe_aligned,
   output logic                    rx_align_err,
   output logic                    rx_auto_stb_userbit,
`ifdef LL_RX_AUTOSYNC_RELOCK_CNT_EN
   output logic [7:0]              rx_relock_cnt,
`endif
   output logic [MARKER_WIDTH-1:0] rx_auto_mrk_userbit
);

   localparam logic [3:0] c_lock_cnt = LOCK_COUNT[3:0];

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_VERIFY = 2'd2,
      ST_LOCKED = 2'd3
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [7:0]   r_word_cnt;
   logic [7:0]   w_word_cnt_nxt;
   logic [3:0]   r_match_cnt;
   logic [3:0]   w_match_cnt_nxt;
   logic [3:0]   w_match_inc;
   logic         r_aligned;
   logic         r_err;
   logic         w_err_nxt;
   logic         w_qstb;
   logic         w_unq_stb;
   logic         w_at_period;

   // A strobe only counts when accompanied by a marker (unless markers are
   // ignored); a bare strobe is an error and is otherwise treated as absent.
   assign w_qstb      = rx_stb_userbit & (NO_MARKER | (|rx_mrk_userbit));
   assign w_unq_stb   = rx_stb_userbit & ~w_qstb;
   assign w_at_period = (r_word_cnt == stb_period);
   assign w_match_inc = r_match_cnt + 4'd1;

   always_comb begin
      w_state_nxt     = r_state;
      w_word_cnt_nxt  = r_word_cnt;
      w_match_cnt_nxt = r_match_cnt;
      w_err_nxt       = w_unq_stb;
      if (!rx_online) begin
         w_state_nxt     = ST_IDLE;
         w_word_cnt_nxt  = 8'd0;
         w_match_cnt_nxt = 4'd0;
         w_err_nxt       = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt     = ST_SEARCH;
               w_word_cnt_nxt  = 8'd0;
               w_match_cnt_nxt = 4'd0;
            end
            ST_SEARCH: begin
               // A zero period means no usable strobe pattern: never leave.
               if (w_qstb && (stb_period != 8'd0)) begin
                  w_word_cnt_nxt  = 8'd1;
                  w_match_cnt_nxt = 4'd1;
                  if (!PERSISTENT_STROBE || (c_lock_cnt == 4'd1))
                     w_state_nxt = ST_LOCKED;
                  else
                     w_state_nxt = ST_VERIFY;
               end
            end
            ST_VERIFY: begin
               w_word_cnt_nxt = r_word_cnt + 8'd1;
               if (w_qstb && w_at_period) begin
                  w_word_cnt_nxt  = 8'd1;
                  w_match_cnt_nxt = w_match_inc;
                  if (w_match_inc == c_lock_cnt)
                     w_state_nxt = ST_LOCKED;
               end else if (w_qstb) begin
                  // Early strobe becomes the new reference.
                  w_err_nxt       = 1'b1;
                  w_word_cnt_nxt  = 8'd1;
                  w_match_cnt_nxt = 4'd1;
               end else if (w_at_period) begin
                  w_err_nxt       = 1'b1;
                  w_state_nxt     = ST_SEARCH;
                  w_word_cnt_nxt  = 8'd0;
                  w_match_cnt_nxt = 4'd0;
               end
            end
            default: begin // ST_LOCKED
               if (PERSISTENT_STROBE) begin
                  w_word_cnt_nxt = r_word_cnt + 8'd1;
                  if (w_qstb && w_at_period) begin
                     w_word_cnt_nxt = 8'd1;
                  end else if (w_qstb || w_at_period) begin
                     w_err_nxt       = 1'b1;
                     w_state_nxt     = ST_SEARCH;
                     w_word_cnt_nxt  = 8'd0;
                     w_match_cnt_nxt = 4'd0;
                  end
               end else if (w_qstb) begin
                  // One-shot sync already consumed; any repeat is an error.
                  w_err_nxt = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         r_state     <= ST_IDLE;
         r_word_cnt  <= 8'd0;
         r_match_cnt <= 4'd0;
         r_aligned   <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_word_cnt  <= w_word_cnt_nxt;
         r_match_cnt <= w_match_cnt_nxt;
         r_aligned   <= (w_state_nxt == ST_LOCKED);
         r_err       <= w_err_nxt;
      end
   end

`ifdef LL_RX_AUTOSYNC_RELOCK_CNT_EN
   logic       w_lock_lost;
   logic [7:0] r_relock_cnt;

   // rx_online drop goes to IDLE, so it never counts as a relock.
   assign w_lock_lost = (r_state == ST_LOCKED) && (w_state_nxt == ST_SEARCH);

   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n)
         r_relock_cnt <= 8'd0;
      else if (w_lock_lost && (r_relock_cnt != 8'hFF))
         r_relock_cnt <= r_relock_cnt + 8'd1;
   end

   assign rx_relock_cnt = r_relock_cnt;
`endif

   assign rx_strobe_aligned   = r_aligned;
   assign rx_align_err        = r_err;
   assign rx_auto_stb_userbit = rx_stb_userbit & r_aligned & PERSISTENT_STROBE;
   assign rx_auto_mrk_userbit = rx_mrk_userbit;

endmodule
`default_nettype wire

// File: tb/tb_ll_rx_auto_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ll_rx_auto_sync
//  Purpose  : Self-checking bench for ll_rx_auto_sync. Three instances share
//             one stimulus: u0 persistent LOCK_COUNT=3, u1 one-shot,
//             u2 persistent NO_MARKER=1 LOCK_COUNT=1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ll_rx_auto_sync;
   localparam int NI = 3;
   localparam int S_IDLE = 0, S_SEARCH = 1, S_VERIFY = 2, S_LOCKED = 3;

   logic       clk_wr = 1'b0;
   logic       rst_wr_n = 1'b0;
   logic       rx_online = 1'b0;
   logic [7:0] stb_period = 8'd4;
   logic       rx_stb_userbit = 1'b0;
   logic [1:0] rx_mrk_userbit = 2'b00;

   logic [NI-1:0] aligned, err, auto_stb;
   logic [1:0]    auto_mrk [NI];
`ifdef LL_RX_AUTOSYNC_RELOCK_CNT_EN
   logic [7:0]    relock [NI];
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_wr = ~clk_wr;

   ll_rx_auto_sync #(.MARKER_WIDTH(2), .PERSISTENT_STROBE(1'b1), .NO_MARKER(1'b0), .LOCK_COUNT(3)) u0 (
      .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .rx_online(rx_online), .stb_period(stb_period),
      .rx_stb_userbit(rx_stb_userbit), .rx_mrk_userbit(rx_mrk_userbit),
      .rx_strobe_aligned(aligned[0]), .rx_align_err(err[0]), .rx_auto_stb_userbit(auto_stb[0]),
`ifdef LL_RX_AUTOSYNC_RELOCK_CNT_EN
      .rx_relock_cnt(relock[0]),
`endif
      .rx_auto_mrk_userbit(auto_mrk[0]));

   ll_rx_auto_sync #(.MARKER_WIDTH(2), .PERSISTENT_STROBE(1'b0), .NO_MARKER(1'b0), .LOCK_COUNT(3)) u1 (
      .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .rx_online(rx_online), .stb_period(stb_period),
      .rx_stb_userbit(rx_stb_userbit), .rx_mrk_userbit(rx_mrk_userbit),
      .rx_strobe_aligned(aligned[1]), .rx_align_err(err[1]), .rx_auto_stb_userbit(auto_stb[1]),
`ifdef LL_RX_AUTOSYNC_RELOCK_CNT_EN
      .rx_relock_cnt(relock[1]),
`endif
      .rx_auto_mrk_userbit(auto_mrk[1]));

   ll_rx_auto_sync #(.MARKER_WIDTH(2), .PERSISTENT_STROBE(1'b1), .NO_MARKER(1'b1), .LOCK_COUNT(1)) u2 (
      .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .rx_online(rx_online), .stb_period(stb_period),
      .rx_stb_userbit(rx_stb_userbit), .rx_mrk_userbit(rx_mrk_userbit),
      .rx_strobe_aligned(aligned[2]), .rx_align_err(err[2]), .rx_auto_stb_userbit(auto_stb[2]),
`ifdef LL_RX_AUTOSYNC_RELOCK_CNT_EN
      .rx_relock_cnt(relock[2]),
`endif
      .rx_auto_mrk_userbit(auto_mrk[2]));

   // ---------------- behavioural model (timestamp based) -------------------
   int m_pers  [NI] = '{1, 0, 1};
   int m_nomrk [NI] = '{0, 0, 1};
   int m_lc    [NI] = '{3, 3, 1};
   int ms      [NI];
   int mref    [NI];
   int mmatch  [NI];
   int mrelock [NI];
   bit maligned[NI];
   bit merr    [NI];
   int cyc = 0;

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         ms[i] = S_IDLE; mref[i] = 0; mmatch[i] = 0;
         mrelock[i] = 0; maligned[i] = 1'b0; merr[i] = 1'b0;
      end
   endtask

   task automatic model_step();
      bit q, unq;
      int gap;
      cyc++;
      for (int i = 0; i < NI; i++) begin
         q   = rx_stb_userbit && (m_nomrk[i] == 1 || rx_mrk_userbit != 2'b00);
         unq = rx_stb_userbit && !q;
         gap = cyc - mref[i];
         merr[i] = 1'b0;
         if (!rx_online) begin
            ms[i] = S_IDLE;
         end else begin
            merr[i] = unq;
            case (ms[i])
               S_IDLE: ms[i] = S_SEARCH;
               S_SEARCH:
                  if (q && stb_period != 0) begin
                     mref[i] = cyc; mmatch[i] = 1;
                     ms[i] = (m_pers[i] == 0 || m_lc[i] == 1) ? S_LOCKED : S_VERIFY;
                  end
               S_VERIFY:
                  if (q && gap == int'(stb_period)) begin
                     mmatch[i]++; mref[i] = cyc;
                     if (mmatch[i] == m_lc[i]) ms[i] = S_LOCKED;
                  end else if (q) begin
                     merr[i] = 1'b1; mref[i] = cyc; mmatch[i] = 1;
                  end else if (gap == int'(stb_period)) begin
                     merr[i] = 1'b1; ms[i] = S_SEARCH;
                  end
               default:
                  if (m_pers[i] == 0) begin
                     if (q) merr[i] = 1'b1;
                  end else if (q && gap == int'(stb_period)) begin
                     mref[i] = cyc;
                  end else if (q || gap == int'(stb_period)) begin
                     merr[i] = 1'b1; ms[i] = S_SEARCH;
                     if (mrelock[i] < 255) mrelock[i]++;
                  end
            endcase
         end
         maligned[i] = (ms[i] == S_LOCKED);
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk_wr or negedge rst_wr_n);
         if (!rst_wr_n) model_reset();
         else           model_step();
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare -------------------------------------
   initial begin
      forever begin
         @(negedge clk_wr);
         for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d aligned", i), 32'(aligned[i]), 32'(maligned[i]));
            check($sformatf("u%0d align_err", i), 32'(err[i]), 32'(merr[i]));
            check($sformatf("u%0d auto_stb", i), 32'(auto_stb[i]),
                  32'(rx_stb_userbit && maligned[i] && m_pers[i] == 1));
            check($sformatf("u%0d auto_mrk", i), 32'(auto_mrk[i]), 32'(rx_mrk_userbit));
`ifdef LL_RX_AUTOSYNC_RELOCK_CNT_EN
            check($sformatf("u%0d relock_cnt", i), 32'(relock[i]), 32'(mrelock[i]));
`endif
         end
      end
   end

   task automatic drive(input logic on, input logic stb, input logic [1:0] mrk);
      rx_online = on; rx_stb_userbit = stb; rx_mrk_userbit = mrk;
      @(posedge clk_wr); #1;
   endtask

   // ---------------- directed stimulus -------------------------------------
   initial begin
      bit stb;
      #12;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("lit reset aligned u%0d", i), 32'(aligned[i]), 0);
         check($sformatf("lit reset err u%0d", i), 32'(err[i]), 0);
      end
      @(posedge clk_wr); #1;
      rst_wr_n = 1'b1;
      stb_period = 8'd4;

      // Lock, forward, early strobe, relock.
      for (int c = 0; c < 40; c++) begin
         stb = (c == 10 || c == 14 || c == 18 || c == 22 || c == 25 ||
                c == 29 || c == 33 || c == 37);
         rx_online = 1'b1; rx_stb_userbit = stb; rx_mrk_userbit = stb ? 2'b01 : 2'b00;
         #1;
         if (c == 22) begin
            check("lit auto_stb u0 at 22", 32'(auto_stb[0]), 1);
            check("lit auto_stb u1 one-shot", 32'(auto_stb[1]), 0);
         end
         @(posedge clk_wr); #1;
         if (c == 10) check("lit u1 oneshot locks", 32'(aligned[1]), 1);
         if (c == 14) check("lit u1 repeat err", 32'(err[1]), 1);
         if (c == 15) check("lit u1 stays aligned", 32'(aligned[1]), 1);
         if (c == 17) check("lit u0 not yet aligned", 32'(aligned[0]), 0);
         if (c == 18) begin
            check("lit u0 aligned at 19", 32'(aligned[0]), 1);
            check("lit model u0 aligned", 32'(maligned[0]), 1);
            check("lit u0 no err", 32'(err[0]), 0);
         end
         if (c == 25) begin
            check("lit u0 early err", 32'(err[0]), 1);
            check("lit u0 early drops aligned", 32'(aligned[0]), 0);
            check("lit model u0 early err", 32'(merr[0]), 1);
         end
         if (c == 36) check("lit u0 relock pending", 32'(aligned[0]), 0);
         if (c == 37) check("lit u0 relocked", 32'(aligned[0]), 1);
      end
`ifdef LL_RX_AUTOSYNC_RELOCK_CNT_EN
      check("lit u0 relock_cnt", 32'(relock[0]), 1);
      check("lit u2 relock_cnt", 32'(relock[2]), 1);
`endif

      // Drop rx_online while locked.
      drive(1'b0, 1'b0, 2'b00);
      check("lit online drop aligned", 32'(aligned[0]), 0);
      check("lit model online drop", 32'(maligned[0]), 0);

      // Unqualified strobe: error for marker-checking instances, lock for u2.
      drive(1'b1, 1'b0, 2'b00);
      drive(1'b1, 1'b0, 2'b00);
      drive(1'b1, 1'b1, 2'b00);
      check("lit u0 unq err", 32'(err[0]), 1);
      check("lit u0 unq no lock", 32'(aligned[0]), 0);
      check("lit u2 nomarker accepted", 32'(aligned[2]), 1);
      check("lit u2 nomarker no err", 32'(err[2]), 0);
      drive(1'b1, 1'b0, 2'b00);
      check("lit u0 unq err one pulse", 32'(err[0]), 0);
      drive(1'b0, 1'b0, 2'b00);

      // stb_period = 0: never align, never err.
      stb_period = 8'd0;
      drive(1'b0, 1'b0, 2'b00);
      for (int c = 0; c < 20; c++) begin
         drive(1'b1, 1'b1, 2'b11);
         check("lit period0 u0 aligned", 32'(aligned[0]), 0);
         check("lit period0 u0 err", 32'(err[0]), 0);
      end
      drive(1'b0, 1'b0, 2'b00);
      stb_period = 8'd4;

      // Async reset mid-VERIFY, then relock and a missing strobe.
      drive(1'b1, 1'b0, 2'b00);
      drive(1'b1, 1'b1, 2'b10);
      drive(1'b1, 1'b0, 2'b00);
      check("lit u1 aligned before reset", 32'(aligned[1]), 1);
      rx_stb_userbit = 1'b1; rx_mrk_userbit = 2'b01;
      #1 rst_wr_n = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("lit async reset aligned u%0d", i), 32'(aligned[i]), 0);
         check($sformatf("lit async reset auto_stb u%0d", i), 32'(auto_stb[i]), 0);
      end
      rx_stb_userbit = 1'b0; rx_mrk_userbit = 2'b00;
      @(posedge clk_wr); #1;
      rst_wr_n = 1'b1;
      for (int c = 0; c < 17; c++) begin
         stb = (c == 3 || c == 7 || c == 11);
         drive(1'b1, stb, stb ? 2'b01 : 2'b00);
         if (c == 10) check("lit post-reset not aligned", 32'(aligned[0]), 0);
         if (c == 11) check("lit post-reset relock", 32'(aligned[0]), 1);
         if (c == 15) begin
            check("lit missing err", 32'(err[0]), 1);
            check("lit missing drops aligned", 32'(aligned[0]), 0);
         end
      end
      drive(1'b0, 1'b0, 2'b00);
      @(posedge clk_wr); #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
